// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters.
// One operation is in flight at a time; its response is held until the owning requester accepts it.
module alu_arbiter #(
  parameter int WIDTH = 64,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OP_W-1:0]  req0_Operation,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OP_W-1:0]  req1_Operation,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OP_W-1:0]  alu_Operation,
  input  logic [WIDTH-1:0] alu_Result,
  input  logic             alu_Overflow,
  input  logic             alu_Zero,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_Result,
  output logic             rsp_Overflow,
  output logic             rsp_Zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             grant_id_q, grant_id_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;

  logic rsp_done;
  logic can_arb;
  logic grant;
  logic pick;

  always_comb begin
    // A response being retired frees the datapath, so the next request can be granted in the same cycle.
    rsp_done = (state_q == S_RESP) && (grant_id_q ? rsp1_ready : rsp0_ready);
    can_arb  = (state_q == S_IDLE) || rsp_done;
    pick     = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
    grant    = can_arb && (req0_valid || req1_valid);

    req0_ready = grant && !pick;
    req1_ready = grant && pick;

    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;

    if (state_q == S_EXEC) begin
      rsp_result_d = alu_Result;
      rsp_ovf_d    = alu_Overflow;
      rsp_zero_d   = alu_Zero;
      rsp0_valid_d = !grant_id_q;
      rsp1_valid_d = grant_id_q;
      state_d      = S_RESP;
    end else begin
      if (rsp_done) begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
      if (grant) begin
        grant_id_d   = pick;
        last_grant_d = pick;
        alu_a_d      = pick ? req1_A : req0_A;
        alu_b_d      = pick ? req1_B : req0_B;
        alu_op_d     = pick ? req1_Operation : req0_Operation;
        state_d      = S_EXEC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_A         = alu_a_q;
  assign alu_B         = alu_b_q;
  assign alu_Operation = alu_op_q;
  assign rsp_Result    = rsp_result_q;
  assign rsp_Overflow  = rsp_ovf_q;
  assign rsp_Zero      = rsp_zero_q;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp1_valid    = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop, a queue scoreboard checks responses.
module tb_alu_arbiter;

  localparam int WIDTH = 64;
  localparam int OP_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [OP_W-1:0]  req0_Operation, req1_Operation;
  logic [WIDTH-1:0] alu_A, alu_B, alu_Result;
  logic [OP_W-1:0]  alu_Operation;
  logic             alu_Overflow, alu_Zero;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp_Result;
  logic             rsp_Overflow, rsp_Zero;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_Operation(req0_Operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_Operation(req1_Operation),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Operation(alu_Operation),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow), .alu_Zero(alu_Zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_Result(rsp_Result), .rsp_Overflow(rsp_Overflow), .rsp_Zero(rsp_Zero)
  );

  // Behavioural ALU with ALU_CU operation encoding.
  always_comb begin
    alu_Result   = '0;
    alu_Overflow = 1'b0;
    case (alu_Operation)
      4'b0000: alu_Result = alu_A & alu_B;
      4'b0001: alu_Result = alu_A | alu_B;
      4'b0010: begin
        alu_Result   = alu_A + alu_B;
        alu_Overflow = (alu_A[WIDTH-1] == alu_B[WIDTH-1]) && (alu_Result[WIDTH-1] != alu_A[WIDTH-1]);
      end
      4'b0110: begin
        alu_Result   = alu_A - alu_B;
        alu_Overflow = (alu_A[WIDTH-1] != alu_B[WIDTH-1]) && (alu_Result[WIDTH-1] != alu_A[WIDTH-1]);
      end
      4'b0111: alu_Result = {{(WIDTH-1){1'b0}}, ($signed(alu_A) < $signed(alu_B))};
      4'b1100: alu_Result = ~(alu_A | alu_B);
      default: alu_Result = '0;
    endcase
    alu_Zero = (alu_Result == '0);
  end

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [WIDTH-1:0] res, input logic ovf, input logic zero);
    exp_t e;
    e.id = id; e.res = res; e.ovf = ovf; e.zero = zero;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic id);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("rsp_unexpected", {63'd0, id}, 64'd2);
    end else begin
      e = exp_q.pop_front();
      n_pop++;
      $display("rsp%0d Result=%h Overflow=%0b Zero=%0b", id, rsp_Result, rsp_Overflow, rsp_Zero);
      chk("rsp_id", {63'd0, id}, {63'd0, e.id});
      chk("rsp_Result", rsp_Result, e.res);
      chk("rsp_Overflow", {63'd0, rsp_Overflow}, {63'd0, e.ovf});
      chk("rsp_Zero", {63'd0, rsp_Zero}, {63'd0, e.zero});
    end
  endtask

  // One clock cycle: monitor at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("rsp_valid_overlap", {63'd0, rsp0_valid && rsp1_valid}, 64'd0);
    chk("req_ready_overlap", {63'd0, req0_ready && req1_ready}, 64'd0);
    if (rsp0_valid && rsp0_ready) pop_check(1'b0);
    if (rsp1_valid && rsp1_ready) pop_check(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [OP_W-1:0] op);
    if (!id) begin
      req0_valid = v; req0_A = a; req0_B = b; req0_Operation = op;
    end else begin
      req1_valid = v; req1_A = a; req1_B = b; req1_Operation = op;
    end
  endtask

  task automatic set_rsp_ready(input logic id, input logic v);
    if (!id) rsp0_ready = v;
    else     rsp1_ready = v;
  endtask

  // Single isolated operation on one requester with full latency checks.
  task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [OP_W-1:0] op, input logic [WIDTH-1:0] res,
                       input logic ovf, input logic zero);
    $display("req%0d A=%h B=%h Op=%b", id, a, b, op);
    set_req(id, 1'b1, a, b, op);
    push(id, res, ovf, zero);
    #2;
    chk("req_ready_granted", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
    chk("req_ready_other", {63'd0, id ? req0_ready : req1_ready}, 64'd0);
    tick();
    set_req(id, 1'b0, a, b, op);
    #2;
    chk("alu_A_latched", alu_A, a);
    chk("alu_Op_latched", {60'd0, alu_Operation}, {60'd0, op});
    chk("rsp_valid_exec", {63'd0, rsp0_valid || rsp1_valid}, 64'd0);
    tick();
    chk("rsp_valid_owner", {63'd0, id ? rsp1_valid : rsp0_valid}, 64'd1);
    chk("rsp_valid_other", {63'd0, id ? rsp0_valid : rsp1_valid}, 64'd0);
    set_rsp_ready(id, 1'b1);
    tick();
    set_rsp_ready(id, 1'b0);
    chk("rsp_valid_cleared", {63'd0, rsp0_valid || rsp1_valid}, 64'd0);
    chk("alu_A_persist", alu_A, a);
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #12;
    chk("reset_alu_A", alu_A, '0);
    chk("reset_rsp_Result", rsp_Result, '0);
    chk("reset_rsp_valids", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic operations on each requester.
    do_op(1'b0, 64'd5, 64'd3, 4'b0010, 64'd8, 1'b0, 1'b0);
    do_op(1'b1, 64'd7, 64'd7, 4'b0110, 64'd0, 1'b0, 1'b1);
    do_op(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000, 1'b1, 1'b0);

    // Both requesters saturated after a reset: grants alternate 0,1,0,1 at one per two cycles.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_req(1'b0, 1'b1, 64'd10, 64'd4, 4'b0010);
    set_req(1'b1, 1'b1, 64'd10, 64'd4, 4'b0110);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    n_pop = 0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 64'd14, 1'b0, 1'b0);
      push(1'b1, 64'd6, 1'b0, 1'b0);
    end
    for (int i = 0; i < 15; i++) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stream_pops", n_pop, 64'd8);
    chk("stream_queue_empty", exp_q.size(), 64'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Response backpressure while the other requester waits.
    set_req(1'b0, 1'b1, 64'd100, 64'd1, 4'b0010);
    push(1'b0, 64'd101, 1'b0, 1'b0);
    tick();
    req0_valid = 1'b0;
    set_req(1'b1, 1'b1, 64'd3, 64'd9, 4'b0000);
    tick();
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
      chk("stall_rsp_Result", rsp_Result, 64'd101);
      chk("stall_req1_ready", {63'd0, req1_ready}, 64'd0);
      tick();
    end
    rsp0_ready = 1'b1;
    push(1'b1, 64'd1, 1'b0, 1'b0);
    #2;
    chk("release_req1_ready", {63'd0, req1_ready}, 64'd1);
    tick();
    rsp0_ready = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("followup_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    tick();
    rsp1_ready = 1'b0;

    // Asynchronous reset in EXEC discards the operation.
    set_req(1'b1, 1'b1, 64'd1, 64'd1, 4'b0010);
    tick();
    req1_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_alu_A", alu_A, '0);
    chk("areset_alu_B", alu_B, '0);
    chk("areset_alu_Op", {60'd0, alu_Operation}, 64'd0);
    chk("areset_rsp_Result", rsp_Result, '0);
    chk("areset_rsp_flags", {62'd0, rsp_Overflow, rsp_Zero}, 64'd0);
    chk("areset_rsp_valids", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("aborted_no_rsp", {62'd0, rsp1_valid, rsp0_valid}, 64'd0);
    end
    set_req(1'b0, 1'b1, 64'd20, 64'd22, 4'b0010);
    set_req(1'b1, 1'b1, 64'd20, 64'd22, 4'b0110);
    push(1'b0, 64'd42, 1'b0, 1'b0);
    #2;
    chk("post_reset_req0_first", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("final_queue_empty", exp_q.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
